id_ex_pipe_reg: RTL

- ID/EX pipeline register for the 5-stage RISC-V core, with integrated load-use hazard detection.
- Captures decoded operands, register addresses and control bits from ID each cycle.
- Presents the ID_EX_REG_* values consumed by EX and the forwarding unit.
- Inserts a bubble and requests an IF/ID hold on a load-use hazard; also handles branch flush and downstream stall.

---
 rtl/id_ex_pipe_reg_if.sv | 67 ++++++
 rtl/id_ex_pipe_reg.sv | 135 +++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline-register bundle: ID-stage inputs, EX-facing registered outputs and IF/ID hold.
// slave = the pipeline register itself; master = the surrounding core (or a testbench).
interface id_ex_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int FUNCT_W = 4
);
  logic               ID_VALID;
  logic [XLEN-1:0]    ID_PC;
  logic [XLEN-1:0]    ID_RS1_DATA;
  logic [XLEN-1:0]    ID_RS2_DATA;
  logic [XLEN-1:0]    ID_IMM;
  logic [4:0]         ID_RS1_ADD;
  logic [4:0]         ID_RS2_ADD;
  logic [4:0]         ID_RD_ADD;
  logic [FUNCT_W-1:0] ID_FUNCT;
  logic               ID_WB_CTRL_RegWrite;
  logic               ID_WB_CTRL_MemtoReg;
  logic               ID_M_CTRL_MemRead;
  logic               ID_M_CTRL_MemWrite;
  logic               ID_EX_CTRL_ALUSrc;
  logic [1:0]         ID_EX_CTRL_ALUOp;
  logic               FLUSH;
  logic               EX_STALL;

  logic               ID_EX_REG_VALID;
  logic [XLEN-1:0]    ID_EX_REG_PC;
  logic [XLEN-1:0]    ID_EX_REG_RS1_DATA;
  logic [XLEN-1:0]    ID_EX_REG_RS2_DATA;
  logic [XLEN-1:0]    ID_EX_REG_IMM;
  logic [4:0]         ID_EX_REG_RS1_ADD;
  logic [4:0]         ID_EX_REG_RS2_ADD;
  logic [4:0]         ID_EX_REG_RD_ADD;
  logic [FUNCT_W-1:0] ID_EX_REG_FUNCT;
  logic               ID_EX_REG_WB_CTRL_RegWrite;
  logic               ID_EX_REG_WB_CTRL_MemtoReg;
  logic               ID_EX_REG_M_CTRL_MemRead;
  logic               ID_EX_REG_M_CTRL_MemWrite;
  logic               ID_EX_REG_EX_CTRL_ALUSrc;
  logic [1:0]         ID_EX_REG_EX_CTRL_ALUOp;
  logic               STALL_IF_ID;

  modport slave (
    input  ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
           ID_RS1_ADD, ID_RS2_ADD, ID_RD_ADD, ID_FUNCT,
           ID_WB_CTRL_RegWrite, ID_WB_CTRL_MemtoReg,
           ID_M_CTRL_MemRead, ID_M_CTRL_MemWrite,
           ID_EX_CTRL_ALUSrc, ID_EX_CTRL_ALUOp, FLUSH, EX_STALL,
    output ID_EX_REG_VALID, ID_EX_REG_PC, ID_EX_REG_RS1_DATA, ID_EX_REG_RS2_DATA,
           ID_EX_REG_IMM, ID_EX_REG_RS1_ADD, ID_EX_REG_RS2_ADD, ID_EX_REG_RD_ADD,
           ID_EX_REG_FUNCT, ID_EX_REG_WB_CTRL_RegWrite, ID_EX_REG_WB_CTRL_MemtoReg,
           ID_EX_REG_M_CTRL_MemRead, ID_EX_REG_M_CTRL_MemWrite,
           ID_EX_REG_EX_CTRL_ALUSrc, ID_EX_REG_EX_CTRL_ALUOp, STALL_IF_ID
  );

  modport master (
    output ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
           ID_RS1_ADD, ID_RS2_ADD, ID_RD_ADD, ID_FUNCT,
           ID_WB_CTRL_RegWrite, ID_WB_CTRL_MemtoReg,
           ID_M_CTRL_MemRead, ID_M_CTRL_MemWrite,
           ID_EX_CTRL_ALUSrc, ID_EX_CTRL_ALUOp, FLUSH, EX_STALL,
    input  ID_EX_REG_VALID, ID_EX_REG_PC, ID_EX_REG_RS1_DATA, ID_EX_REG_RS2_DATA,
           ID_EX_REG_IMM, ID_EX_REG_RS1_ADD, ID_EX_REG_RS2_ADD, ID_EX_REG_RD_ADD,
           ID_EX_REG_FUNCT, ID_EX_REG_WB_CTRL_RegWrite, ID_EX_REG_WB_CTRL_MemtoReg,
           ID_EX_REG_M_CTRL_MemRead, ID_EX_REG_M_CTRL_MemWrite,
           ID_EX_REG_EX_CTRL_ALUSrc, ID_EX_REG_EX_CTRL_ALUOp, STALL_IF_ID
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and downstream hold.
// Define ID_EX_HAZARD_PERF_EN to add saturating bubble/flush event counters.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int FUNCT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  id_ex_pipe_reg_if.slave bus
`ifdef ID_EX_HAZARD_PERF_EN
  ,
  output logic [31:0]     HAZ_BUBBLE_CNT,
  output logic [31:0]     HAZ_FLUSH_CNT
`endif
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1_add;
    logic [4:0]         rs2_add;
    logic [4:0]         rd_add;
    logic [FUNCT_W-1:0] funct;
    logic               reg_write;
    logic               memto_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic [1:0]         alu_op;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d, id_fields;
  logic    load_use;
  logic    bubble_evt;

  always_comb begin
    id_fields           = '0;
    id_fields.valid     = bus.ID_VALID;
    id_fields.pc        = bus.ID_PC;
    id_fields.rs1_data  = bus.ID_RS1_DATA;
    id_fields.rs2_data  = bus.ID_RS2_DATA;
    id_fields.imm       = bus.ID_IMM;
    id_fields.rs1_add   = bus.ID_RS1_ADD;
    id_fields.rs2_add   = bus.ID_RS2_ADD;
    id_fields.rd_add    = bus.ID_RD_ADD;
    id_fields.funct     = bus.ID_FUNCT;
    id_fields.reg_write = bus.ID_WB_CTRL_RegWrite;
    id_fields.memto_reg = bus.ID_WB_CTRL_MemtoReg;
    id_fields.mem_read  = bus.ID_M_CTRL_MemRead;
    id_fields.mem_write = bus.ID_M_CTRL_MemWrite;
    id_fields.alu_src   = bus.ID_EX_CTRL_ALUSrc;
    id_fields.alu_op    = bus.ID_EX_CTRL_ALUOp;
  end

  // Hazard is judged from the registered load only, so a bubble clears it after one cycle.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_add != 5'd0) && bus.ID_VALID &&
                    ((ex_q.rd_add == bus.ID_RS1_ADD) || (ex_q.rd_add == bus.ID_RS2_ADD));

  assign bus.STALL_IF_ID = !bus.FLUSH && (bus.EX_STALL || load_use);
  assign bubble_evt      = !bus.FLUSH && !bus.EX_STALL && load_use;

  // A bubble is all-zero: no valid, no controls, x0 addresses, zeroed data.
  always_comb begin
    ex_d = ex_q;
    if (bus.FLUSH) begin
      ex_d = '0;
    end else if (bus.EX_STALL) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ID_EX_REG_VALID            = ex_q.valid;
  assign bus.ID_EX_REG_PC               = ex_q.pc;
  assign bus.ID_EX_REG_RS1_DATA         = ex_q.rs1_data;
  assign bus.ID_EX_REG_RS2_DATA         = ex_q.rs2_data;
  assign bus.ID_EX_REG_IMM              = ex_q.imm;
  assign bus.ID_EX_REG_RS1_ADD          = ex_q.rs1_add;
  assign bus.ID_EX_REG_RS2_ADD          = ex_q.rs2_add;
  assign bus.ID_EX_REG_RD_ADD           = ex_q.rd_add;
  assign bus.ID_EX_REG_FUNCT            = ex_q.funct;
  assign bus.ID_EX_REG_WB_CTRL_RegWrite = ex_q.reg_write;
  assign bus.ID_EX_REG_WB_CTRL_MemtoReg = ex_q.memto_reg;
  assign bus.ID_EX_REG_M_CTRL_MemRead   = ex_q.mem_read;
  assign bus.ID_EX_REG_M_CTRL_MemWrite  = ex_q.mem_write;
  assign bus.ID_EX_REG_EX_CTRL_ALUSrc   = ex_q.alu_src;
  assign bus.ID_EX_REG_EX_CTRL_ALUOp    = ex_q.alu_op;

`ifdef ID_EX_HAZARD_PERF_EN
  logic [31:0] bub_cnt_q, bub_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bub_cnt_d   = bub_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bubble_evt && (bub_cnt_q != 32'hFFFF_FFFF)) begin
      bub_cnt_d = bub_cnt_q + 32'd1;
    end
    if (bus.FLUSH && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bub_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      bub_cnt_q   <= bub_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign HAZ_BUBBLE_CNT = bub_cnt_q;
  assign HAZ_FLUSH_CNT  = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = bubble_evt;
`endif

endmodule
